sbox_compress_ctrl: RTL

//  Sequencer for the post-processing 5->4 S-box stage of the TRNG.
//  - Collects raw ring-oscillator bits serially into 5-bit groups.
//  - Presents each group to one shared external combinational S-box (SBOX_IN/SBOX_OUT).
//  - Packs the 4-bit results MSB-first into an OUT_W-bit word.
//  - Hands the word downstream with a valid/ready handshake.

---
 rtl/sbox_compress_ctrl_if.sv | 24 ++
 rtl/sbox_compress_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sbox_compress_ctrl_if.sv
// rtl/sbox_compress_ctrl_if.sv - bit, S-box and output-word signals of the S-box compression sequencer
interface sbox_compress_ctrl_if #(
  parameter int OUT_W  = 32,
  parameter int DROP_W = 8
);
  logic              i_bit_in;
  logic              i_bit_valid;
  logic [4:0]        o_sbox_in;
  logic [3:0]        i_sbox_out;
  logic [OUT_W-1:0]  o_d_out;
  logic              o_d_valid;
  logic              i_d_ready;
  logic [DROP_W-1:0] o_drop_cnt;

  modport master (
    input  i_bit_in, i_bit_valid, i_sbox_out, i_d_ready,
    output o_sbox_in, o_d_out, o_d_valid, o_drop_cnt
  );

  modport slave (
    output i_bit_in, i_bit_valid, i_sbox_out, i_d_ready,
    input  o_sbox_in, o_d_out, o_d_valid, o_drop_cnt
  );
endinterface

// File: rtl/sbox_compress_ctrl.sv
// rtl/sbox_compress_ctrl.sv - 5->4 S-box compression sequencer; optional SBOX_CHAIN_EN feeds the previous result into the next address
module sbox_compress_ctrl #(
  parameter int OUT_W  = 32,
  parameter int DROP_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sbox_compress_ctrl_if.master bus
);
  localparam int NIB = OUT_W / 4;
  localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [NW-1:0] LAST_NIB = NW'(NIB - 1);

  typedef enum logic [1:0] {S_COLLECT, S_LOOKUP, S_OUTPUT} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_b_cnt;
  logic [NW-1:0]     r_n_cnt;
  logic [3:0]        r_sh;
  logic [OUT_W-5:0]  r_pack;
  logic [4:0]        r_sbox_in;
  logic [OUT_W-1:0]  r_d_out;
  logic              r_d_valid;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_accept, w_group_done, w_lookup, w_word_done, w_handshake, w_drop;
  logic [4:0]        w_group;
  logic [OUT_W-1:0]  w_pack_nxt;

`ifdef SBOX_CHAIN_EN
  logic [3:0] r_prev;

  // previous S-box result, kept across words, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_rst)         r_prev <= '0;
    else if (w_lookup) r_prev <= bus.i_sbox_out;
  end

  assign w_group = {r_sh, bus.i_bit_in} ^ {1'b0, r_prev};
`else
  assign w_group = {r_sh, bus.i_bit_in};
`endif

  assign w_pack_nxt = {r_pack, bus.i_sbox_out};

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_COLLECT;
    else       r_state <= w_state_nxt;
  end

  // next state and per-cycle control strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_group_done = 1'b0;
    w_lookup     = 1'b0;
    w_word_done  = 1'b0;
    w_handshake  = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_COLLECT: begin
        w_accept     = bus.i_bit_valid;
        w_group_done = bus.i_bit_valid && (r_b_cnt == 3'd4);
        if (w_group_done) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        // b_cnt is 0 on entry, so a group cannot complete here
        w_accept    = bus.i_bit_valid;
        w_lookup    = 1'b1;
        w_word_done = (r_n_cnt == LAST_NIB);
        w_state_nxt = w_word_done ? S_OUTPUT : S_COLLECT;
      end
      S_OUTPUT: begin
        w_drop      = bus.i_bit_valid;
        w_handshake = r_d_valid && bus.i_d_ready;
        if (w_handshake) w_state_nxt = S_COLLECT;
      end
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  // bit collection, nibble packing, word hand-off and drop counting
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_b_cnt    <= '0;
      r_n_cnt    <= '0;
      r_sh       <= '0;
      r_pack     <= '0;
      r_sbox_in  <= '0;
      r_d_out    <= '0;
      r_d_valid  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_sh <= {r_sh[2:0], bus.i_bit_in};
        if (w_group_done) begin
          r_sbox_in <= w_group;
          r_b_cnt   <= '0;
        end else begin
          r_b_cnt <= r_b_cnt + 3'd1;
        end
      end
      if (w_lookup) begin
        r_pack <= w_pack_nxt[OUT_W-5:0];
        if (w_word_done) begin
          r_n_cnt   <= '0;
          r_d_out   <= w_pack_nxt;
          r_d_valid <= 1'b1;
        end else begin
          r_n_cnt <= r_n_cnt + NW'(1);
        end
      end
      if (w_handshake) r_d_valid <= 1'b0;
      if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
    end
  end

  assign bus.o_sbox_in  = r_sbox_in;
  assign bus.o_d_out    = r_d_out;
  assign bus.o_d_valid  = r_d_valid;
  assign bus.o_drop_cnt = r_drop_cnt;
endmodule
